// File: rtl/ma_stage_pkg.sv
// +----------------------------------------------------------------------+
// | ma_stage_pkg : funct3 codes, byte enables and FSM encoding (rev 1.0)  |
// +----------------------------------------------------------------------+
`default_nettype none

package ma_stage_pkg;

  localparam logic [2:0] c_LB  = 3'b000;
  localparam logic [2:0] c_LH  = 3'b001;
  localparam logic [2:0] c_LW  = 3'b010;
  localparam logic [2:0] c_LBU = 3'b100;
  localparam logic [2:0] c_LHU = 3'b101;
  localparam logic [2:0] c_SB  = 3'b000;
  localparam logic [2:0] c_SH  = 3'b001;
  localparam logic [2:0] c_SW  = 3'b010;

  localparam logic [3:0] c_BE_ALL = 4'b1111;
  localparam logic [3:0] c_BE_LO  = 4'b0011;
  localparam logic [3:0] c_BE_HI  = 4'b1100;
  localparam logic [3:0] c_BE_B0  = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } ma_state_e;

  // Unknown funct3 codes are never flagged; they behave as word accesses.
  function automatic logic is_misaligned(input logic [2:0] code, input logic [1:0] adr_lo);
    return (((code == c_LH) || (code == c_LHU)) && adr_lo[0]) ||
           ((code == c_LW) && (adr_lo != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/ma_stage_if.sv
// +----------------------------------------------------------------------+
// | ma_stage_if : req/ack data-memory bus between MA stage and memory     |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface ma_stage_if #(
  parameter int ADR_W = 30
);
  logic             d_req;
  logic             d_we;
  logic [ADR_W-1:0] d_adr;
  logic [3:0]       d_be;
  logic [31:0]      d_wdata;
  logic [31:0]      d_rdata;
  logic             d_ack;

  modport master (
    output d_req, d_we, d_adr, d_be, d_wdata,
    input  d_rdata, d_ack
  );

  modport slave (
    input  d_req, d_we, d_adr, d_be, d_wdata,
    output d_rdata, d_ack
  );
endinterface

`default_nettype wire

// File: rtl/ma_stage_ld_align.sv
// +----------------------------------------------------------------------+
// | ma_stage_ld_align : load lane select and sign/zero extension (rev 1.0)|
// +----------------------------------------------------------------------+
`default_nettype none

module ma_stage_ld_align
  import ma_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  adr_lo,
  input  logic [2:0]  code,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (adr_lo)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = adr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (code)
      c_LB:    data = {{24{w_byte[7]}}, w_byte};
      c_LH:    data = {{16{w_half[15]}}, w_half};
      c_LBU:   data = {24'd0, w_byte};
      c_LHU:   data = {16'd0, w_half};
      default: data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ma_stage.sv
// +----------------------------------------------------------------------+
// | ma_stage : RV32I memory-access stage with WB/WB2 registers (rev 1.0)  |
// +----------------------------------------------------------------------+
`default_nettype none

module ma_stage
  import ma_stage_pkg::*;
#(
  parameter int ADR_W = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_ld_ma,
  input  logic        cmd_st_ma,
  input  logic [4:0]  rd_adr_ma,
  input  logic [31:0] rd_data_ma,
  input  logic        wbk_rd_reg_ma,
  input  logic [31:0] st_data_ma,
  input  logic [2:0]  ldst_code_ma,
  input  logic        stall,
  input  logic        rst_pipe,
  ma_stage_if.master  dbus,
  output logic        ma_stall,
  output logic        misalign_ma,
  output logic [4:0]  rd_adr_wb,
  output logic [31:0] wbk_data_wb,
  output logic        wbk_rd_reg_wb,
  output logic [4:0]  rd_adr_wb2,
  output logic [31:0] wbk_data_wb2,
  output logic        wbk_rd_reg_wb2
);

  ma_state_e        state_q, state_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [3:0]       be_q, be_d;
  logic             we_q, we_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [2:0]       code_q, code_d;
  logic [1:0]       adr_lo_q, adr_lo_d;
  logic [4:0]       rd_adr_wb_q, rd_adr_wb_d, rd_adr_wb2_q, rd_adr_wb2_d;
  logic [31:0]      wbk_data_wb_q, wbk_data_wb_d, wbk_data_wb2_q, wbk_data_wb2_d;
  logic             wbk_rd_reg_wb_q, wbk_rd_reg_wb_d, wbk_rd_reg_wb2_q, wbk_rd_reg_wb2_d;

  logic        w_mem, w_mis, w_idle, w_issue, w_pending;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ld_data;

  assign w_mem     = cmd_ld_ma | cmd_st_ma;
  assign w_mis     = is_misaligned(ldst_code_ma, rd_data_ma[1:0]);
  assign w_idle    = (state_q == ST_IDLE);
  assign w_issue   = w_idle & w_mem & ~w_mis & ~rst_pipe;
  assign w_pending = (state_q == ST_WAIT) | (state_q == ST_DRAIN);

  assign ma_stall    = w_issue | w_pending;
  assign misalign_ma = w_idle & w_mem & w_mis;

  always_comb begin
    w_be    = c_BE_ALL;
    w_wdata = st_data_ma;
    if (cmd_st_ma) begin
      case (ldst_code_ma)
        c_SB: begin
          w_be    = c_BE_B0 << rd_data_ma[1:0];
          w_wdata = {4{st_data_ma[7:0]}};
        end
        c_SH: begin
          w_be    = rd_data_ma[1] ? c_BE_HI : c_BE_LO;
          w_wdata = {2{st_data_ma[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Fields come straight from MA on the issue cycle, then from the latched
  // copy so a flush cannot disturb an outstanding request.
  assign dbus.d_req   = w_issue | w_pending;
  assign dbus.d_adr   = w_issue ? rd_data_ma[31 -: ADR_W] : (w_pending ? adr_q : '0);
  assign dbus.d_be    = w_issue ? w_be : (w_pending ? be_q : 4'd0);
  assign dbus.d_we    = w_issue ? cmd_st_ma : (w_pending & we_q);
  assign dbus.d_wdata = w_issue ? w_wdata : (w_pending ? wdata_q : 32'd0);

  ma_stage_ld_align u_ld_align (
    .rdata  (rdata_q),
    .adr_lo (adr_lo_q),
    .code   (code_q),
    .data   (w_ld_data)
  );

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    adr_d    = adr_q;
    be_d     = be_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    code_d   = code_q;
    adr_lo_d = adr_lo_q;
    if (w_issue) begin
      adr_d    = rd_data_ma[31 -: ADR_W];
      be_d     = w_be;
      we_d     = cmd_st_ma;
      wdata_d  = w_wdata;
      code_d   = ldst_code_ma;
      adr_lo_d = rd_data_ma[1:0];
    end
    case (state_q)
      ST_IDLE: begin
        if (w_issue) begin
          if (dbus.d_ack) begin
            state_d = ST_DONE;
            rdata_d = dbus.d_rdata;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // An ack coinciding with a flush completes the bus cycle but the data is dropped.
        if (dbus.d_ack) begin
          state_d = rst_pipe ? ST_IDLE : ST_DONE;
          rdata_d = dbus.d_rdata;
        end else if (rst_pipe) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (rst_pipe || !stall) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (dbus.d_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_adr_wb_d      = rd_adr_wb_q;
    wbk_data_wb_d    = wbk_data_wb_q;
    wbk_rd_reg_wb_d  = wbk_rd_reg_wb_q;
    rd_adr_wb2_d     = rd_adr_wb2_q;
    wbk_data_wb2_d   = wbk_data_wb2_q;
    wbk_rd_reg_wb2_d = wbk_rd_reg_wb2_q;
    if (rst_pipe) begin
      rd_adr_wb_d      = 5'd0;
      wbk_data_wb_d    = 32'd0;
      wbk_rd_reg_wb_d  = 1'b0;
      rd_adr_wb2_d     = 5'd0;
      wbk_data_wb2_d   = 32'd0;
      wbk_rd_reg_wb2_d = 1'b0;
    end else if (!stall) begin
      rd_adr_wb_d      = rd_adr_ma;
      wbk_data_wb_d    = cmd_ld_ma ? w_ld_data : rd_data_ma;
      wbk_rd_reg_wb_d  = wbk_rd_reg_ma & ~misalign_ma;
      rd_adr_wb2_d     = rd_adr_wb_q;
      wbk_data_wb2_d   = wbk_data_wb_q;
      wbk_rd_reg_wb2_d = wbk_rd_reg_wb_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      adr_q            <= '0;
      be_q             <= 4'd0;
      we_q             <= 1'b0;
      wdata_q          <= 32'd0;
      rdata_q          <= 32'd0;
      code_q           <= 3'd0;
      adr_lo_q         <= 2'd0;
      rd_adr_wb_q      <= 5'd0;
      wbk_data_wb_q    <= 32'd0;
      wbk_rd_reg_wb_q  <= 1'b0;
      rd_adr_wb2_q     <= 5'd0;
      wbk_data_wb2_q   <= 32'd0;
      wbk_rd_reg_wb2_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      adr_q            <= adr_d;
      be_q             <= be_d;
      we_q             <= we_d;
      wdata_q          <= wdata_d;
      rdata_q          <= rdata_d;
      code_q           <= code_d;
      adr_lo_q         <= adr_lo_d;
      rd_adr_wb_q      <= rd_adr_wb_d;
      wbk_data_wb_q    <= wbk_data_wb_d;
      wbk_rd_reg_wb_q  <= wbk_rd_reg_wb_d;
      rd_adr_wb2_q     <= rd_adr_wb2_d;
      wbk_data_wb2_q   <= wbk_data_wb2_d;
      wbk_rd_reg_wb2_q <= wbk_rd_reg_wb2_d;
    end
  end

  assign rd_adr_wb      = rd_adr_wb_q;
  assign wbk_data_wb    = wbk_data_wb_q;
  assign wbk_rd_reg_wb  = wbk_rd_reg_wb_q;
  assign rd_adr_wb2     = rd_adr_wb2_q;
  assign wbk_data_wb2   = wbk_data_wb2_q;
  assign wbk_rd_reg_wb2 = wbk_rd_reg_wb2_q;

endmodule

`default_nettype wire

// File: tb/tb_ma_stage.sv
// +----------------------------------------------------------------------+
// | tb_ma_stage : directed self-checking bench for ma_stage (rev 1.0)     |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ma_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_ld_ma, cmd_st_ma, wbk_rd_reg_ma, rst_pipe, ext_stall;
  logic [4:0]  rd_adr_ma;
  logic [31:0] rd_data_ma, st_data_ma;
  logic [2:0]  ldst_code_ma;
  logic        stall, ma_stall, misalign_ma;
  logic [4:0]  rd_adr_wb, rd_adr_wb2;
  logic [31:0] wbk_data_wb, wbk_data_wb2;
  logic        wbk_rd_reg_wb, wbk_rd_reg_wb2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ma_stage_if #(.ADR_W(30)) dbus ();

  assign stall = ma_stall | ext_stall;

  ma_stage #(.ADR_W(30)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_ld_ma      (cmd_ld_ma),
    .cmd_st_ma      (cmd_st_ma),
    .rd_adr_ma      (rd_adr_ma),
    .rd_data_ma     (rd_data_ma),
    .wbk_rd_reg_ma  (wbk_rd_reg_ma),
    .st_data_ma     (st_data_ma),
    .ldst_code_ma   (ldst_code_ma),
    .stall          (stall),
    .rst_pipe       (rst_pipe),
    .dbus           (dbus),
    .ma_stall       (ma_stall),
    .misalign_ma    (misalign_ma),
    .rd_adr_wb      (rd_adr_wb),
    .wbk_data_wb    (wbk_data_wb),
    .wbk_rd_reg_wb  (wbk_rd_reg_wb),
    .rd_adr_wb2     (rd_adr_wb2),
    .wbk_data_wb2   (wbk_data_wb2),
    .wbk_rd_reg_wb2 (wbk_rd_reg_wb2)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  code;
    logic [4:0]  rd;
    logic        wbk;
    logic [31:0] adr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          dly;
    logic        mis;
    logic [31:0] e_adr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    int          e_stall;
    logic        e_we;
    logic [31:0] e_data;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] code, input logic [4:0] rd,
                       input logic wbk, input logic [31:0] adr, input logic [31:0] sdata);
    cmd_ld_ma     = ld;
    cmd_st_ma     = st;
    ldst_code_ma  = code;
    rd_adr_ma     = rd;
    wbk_rd_reg_ma = wbk;
    rd_data_ma    = adr;
    st_data_ma    = sdata;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 32'd0, 32'd0);
  endtask

  // One instruction through MA; the bus slave acks after v.dly wait cycles.
  task automatic run_vec(input vec_t v, input int idx);
    int nstall = 0;
    int nreq   = 0;
    bit left   = 0;
    @(posedge clk); #1;
    drive(v.ld, v.st, v.code, v.rd, v.wbk, v.adr, v.sdata);
    dbus.d_ack = 1'b0;
    for (int c = 0; c < 20 && !left; c++) begin
      @(negedge clk);
      if (c == 0) chk($sformatf("v%0d misalign", idx), {31'd0, misalign_ma}, {31'd0, v.mis});
      if (dbus.d_req) begin
        if (nreq == 0) begin
          chk($sformatf("v%0d d_adr", idx), {2'd0, dbus.d_adr}, v.e_adr);
          chk($sformatf("v%0d d_be", idx), {28'd0, dbus.d_be}, {28'd0, v.e_be});
          chk($sformatf("v%0d d_we", idx), {31'd0, dbus.d_we}, {31'd0, v.st});
          if (v.st) chk($sformatf("v%0d d_wdata", idx), dbus.d_wdata, v.e_wdata);
        end
        if (nreq == v.dly) begin
          dbus.d_ack   = 1'b1;
          dbus.d_rdata = v.rdata;
        end
        nreq++;
      end
      if (ma_stall) nstall++;
      if (!stall) left = 1;
      @(posedge clk); #1;
      dbus.d_ack   = 1'b0;
      dbus.d_rdata = 32'd0;
    end
    nop();
    chk($sformatf("v%0d completed", idx), {31'd0, left}, 32'd1);
    chk($sformatf("v%0d stall_cycles", idx), nstall, v.e_stall);
    chk($sformatf("v%0d req_cycles", idx), nreq, ((v.ld | v.st) && !v.mis) ? v.dly + 1 : 0);
    chk($sformatf("v%0d wb_we", idx), {31'd0, wbk_rd_reg_wb}, {31'd0, v.e_we});
    chk($sformatf("v%0d wb_rd", idx), {27'd0, rd_adr_wb}, {27'd0, v.rd});
    if (v.e_we) chk($sformatf("v%0d wb_data", idx), wbk_data_wb, v.e_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    //          ld    st    code    rd     wbk   adr           sdata         rdata         dly mis   e_adr     e_be   e_wdata       st we    e_data
    vt[0]  = '{1'b0, 1'b1, 3'b010, 5'd0,  1'b0, 32'h00000100, 32'h11223344, 32'h00000000, 0, 1'b0, 32'h40, 4'hF, 32'h11223344, 1, 1'b0, 32'h00000000};
    vt[1]  = '{1'b1, 1'b0, 3'b000, 5'd5,  1'b1, 32'h00000103, 32'h00000000, 32'h80FFFFFF, 3, 1'b0, 32'h40, 4'hF, 32'h00000000, 4, 1'b1, 32'hFFFFFF80};
    vt[2]  = '{1'b1, 1'b0, 3'b100, 5'd6,  1'b1, 32'h00000103, 32'h00000000, 32'h80FFFFFF, 3, 1'b0, 32'h40, 4'hF, 32'h00000000, 4, 1'b1, 32'h00000080};
    vt[3]  = '{1'b0, 1'b1, 3'b001, 5'd0,  1'b0, 32'h00000202, 32'h0000BEEF, 32'h00000000, 1, 1'b0, 32'h80, 4'hC, 32'hBEEFBEEF, 2, 1'b0, 32'h00000000};
    vt[4]  = '{1'b1, 1'b0, 3'b101, 5'd7,  1'b1, 32'h00000202, 32'h00000000, 32'hBEEF0000, 0, 1'b0, 32'h80, 4'hF, 32'h00000000, 1, 1'b1, 32'h0000BEEF};
    vt[5]  = '{1'b1, 1'b0, 3'b010, 5'd8,  1'b1, 32'h00000101, 32'h00000000, 32'h00000000, 0, 1'b1, 32'h00, 4'h0, 32'h00000000, 0, 1'b0, 32'h00000000};
    vt[6]  = '{1'b0, 1'b1, 3'b000, 5'd0,  1'b0, 32'h00000001, 32'h000000A5, 32'h00000000, 0, 1'b0, 32'h00, 4'h2, 32'hA5A5A5A5, 1, 1'b0, 32'h00000000};
    vt[7]  = '{1'b1, 1'b0, 3'b001, 5'd9,  1'b1, 32'h00000002, 32'h00000000, 32'h80017FFF, 2, 1'b0, 32'h00, 4'hF, 32'h00000000, 3, 1'b1, 32'hFFFF8001};
    vt[8]  = '{1'b1, 1'b0, 3'b010, 5'd10, 1'b1, 32'h00000008, 32'h00000000, 32'hDEADBEEF, 0, 1'b0, 32'h02, 4'hF, 32'h00000000, 1, 1'b1, 32'hDEADBEEF};
    vt[9]  = '{1'b0, 1'b0, 3'b000, 5'd7,  1'b1, 32'h12345678, 32'h00000000, 32'h00000000, 0, 1'b0, 32'h00, 4'h0, 32'h00000000, 0, 1'b1, 32'h12345678};
    vt[10] = '{1'b0, 1'b1, 3'b001, 5'd0,  1'b0, 32'h00000203, 32'h00001234, 32'h00000000, 0, 1'b1, 32'h00, 4'h0, 32'h00000000, 0, 1'b0, 32'h00000000};
    vt[11] = '{1'b1, 1'b0, 3'b000, 5'd11, 1'b1, 32'h00000000, 32'h00000000, 32'h0000007F, 1, 1'b0, 32'h00, 4'hF, 32'h00000000, 2, 1'b1, 32'h0000007F};
    vt[12] = '{1'b1, 1'b0, 3'b011, 5'd12, 1'b1, 32'h00000004, 32'h00000000, 32'h01020304, 0, 1'b0, 32'h01, 4'hF, 32'h00000000, 1, 1'b1, 32'h01020304};

    rst = 1'b1; rst_pipe = 1'b0; ext_stall = 1'b0;
    dbus.d_ack = 1'b0; dbus.d_rdata = 32'd0;
    nop();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst d_req", {31'd0, dbus.d_req}, 32'd0);
    chk("rst ma_stall", {31'd0, ma_stall}, 32'd0);
    chk("rst misalign", {31'd0, misalign_ma}, 32'd0);
    chk("rst d_be", {28'd0, dbus.d_be}, 32'd0);
    chk("rst wb", {rd_adr_wb, wbk_rd_reg_wb, 26'd0}, 32'd0);
    chk("rst wb_data", wbk_data_wb, 32'd0);
    chk("rst wb2", {rd_adr_wb2, wbk_rd_reg_wb2, 26'd0}, 32'd0);
    chk("rst wb2_data", wbk_data_wb2, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(vt[i], i);

    // Flush while a load waits: request must stay up until the ack drains it.
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 3'b010, 5'd9, 1'b1, 32'h00000010, 32'd0);
    @(negedge clk);
    chk("rp issue d_req", {31'd0, dbus.d_req}, 32'd1);
    @(posedge clk); #1;
    rst_pipe = 1'b1;
    nop();
    @(negedge clk);
    chk("rp wait d_req", {31'd0, dbus.d_req}, 32'd1);
    chk("rp wait d_adr", {2'd0, dbus.d_adr}, 32'h4);
    chk("rp wait ma_stall", {31'd0, ma_stall}, 32'd1);
    chk("rp wait wb2 held", {27'd0, rd_adr_wb2}, 32'd12);
    chk("rp wait wb2_we held", {31'd0, wbk_rd_reg_wb2}, 32'd1);
    @(posedge clk); #1 rst_pipe = 1'b0;
    @(negedge clk);
    chk("rp drain d_req", {31'd0, dbus.d_req}, 32'd1);
    chk("rp drain d_adr", {2'd0, dbus.d_adr}, 32'h4);
    chk("rp drain ma_stall", {31'd0, ma_stall}, 32'd1);
    chk("rp wb cleared", {rd_adr_wb, wbk_rd_reg_wb, 26'd0}, 32'd0);
    chk("rp wb2 cleared", {rd_adr_wb2, wbk_rd_reg_wb2, 26'd0}, 32'd0);
    chk("rp wb2_data cleared", wbk_data_wb2, 32'd0);
    dbus.d_ack = 1'b1; dbus.d_rdata = 32'h00000055;
    @(posedge clk); #1 dbus.d_ack = 1'b0;
    @(negedge clk);
    chk("rp idle d_req", {31'd0, dbus.d_req}, 32'd0);
    chk("rp idle ma_stall", {31'd0, ma_stall}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rp no wb write", {31'd0, wbk_rd_reg_wb}, 32'd0);
    chk("rp wb_data", wbk_data_wb, 32'd0);

    // Core reset while a request waits returns the FSM to IDLE.
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 3'b010, 5'd2, 1'b1, 32'h00000020, 32'd0);
    @(negedge clk);
    chk("rstw issue d_req", {31'd0, dbus.d_req}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; nop();
    @(negedge clk);
    chk("rstw d_req", {31'd0, dbus.d_req}, 32'd0);
    chk("rstw ma_stall", {31'd0, ma_stall}, 32'd0);

    // External stall holds WB; WB2 picks it up one cycle after release.
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 5'd3, 1'b1, 32'h00000005, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 5'd4, 1'b1, 32'h00000009, 32'd0);
    ext_stall = 1'b1;
    @(negedge clk);
    chk("stl wb rd c1", {27'd0, rd_adr_wb}, 32'd3);
    chk("stl wb data c1", wbk_data_wb, 32'h5);
    chk("stl wb we c1", {31'd0, wbk_rd_reg_wb}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stl wb rd c2", {27'd0, rd_adr_wb}, 32'd3);
    chk("stl wb data c2", wbk_data_wb, 32'h5);
    chk("stl wb2 rd c2", {27'd0, rd_adr_wb2}, 32'd0);
    @(posedge clk); #1 ext_stall = 1'b0;
    @(negedge clk);
    chk("stl wb2 rd rel", {27'd0, rd_adr_wb2}, 32'd0);
    @(posedge clk); #1 nop();
    @(negedge clk);
    chk("stl wb2 rd", {27'd0, rd_adr_wb2}, 32'd3);
    chk("stl wb2 data", wbk_data_wb2, 32'h5);
    chk("stl wb2 we", {31'd0, wbk_rd_reg_wb2}, 32'd1);
    chk("stl wb rd next", {27'd0, rd_adr_wb}, 32'd4);
    chk("stl wb data next", wbk_data_wb, 32'h9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
